memory_access: RTL

- Pipeline memory stage, directly downstream of the execute stage and upstream of writeback.
- Consumes the execute→memory pipeline registers.
- Performs data-memory loads and stores over a req/ack bus, aligning store lanes by byte offset.
- Stalls the pipeline while an access is outstanding and registers the writeback result.
- Provides the memory-stage forwarding value back to execute.

---
 rtl/memory_access_pkg.sv | 40 ++++
 rtl/memory_access_store_align.sv | 27 ++
 rtl/memory_access.sv | 87 ++++++++
 3 files changed

// File: rtl/memory_access_pkg.sv
// Shared constants, state encoding and alignment rules for the memory stage.
package memory_access_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int OFF_W     = 2;

  localparam logic REG_D_DATA_SEL_ALU = 1'b0;
  localparam logic REG_D_DATA_SEL_MEM = 1'b1;

  localparam logic [NUM_LANES-1:0] MEM_SIZE_NONE = 4'b0000;
  localparam logic [NUM_LANES-1:0] MEM_SIZE_BYTE = 4'b0001;
  localparam logic [NUM_LANES-1:0] MEM_SIZE_HALF = 4'b0011;
  localparam logic [NUM_LANES-1:0] MEM_SIZE_WORD = 4'b1111;

  typedef enum logic {
    MEM_STATE_IDLE = 1'b0,
    MEM_STATE_WAIT = 1'b1
  } mem_state_e;

  // Loads are word-only; stores must sit on their natural size boundary.
  function automatic logic is_misaligned(input logic load,
                                         input logic [NUM_LANES-1:0] size,
                                         input logic [OFF_W-1:0] off);
    logic mis;
    mis = 1'b0;
    if (load) begin
      mis = (off != '0);
    end else begin
      case (size)
        MEM_SIZE_BYTE: mis = 1'b0;
        MEM_SIZE_HALF: mis = off[0];
        MEM_SIZE_WORD: mis = (off != '0);
        default:       mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_store_align.sv
// Per-lane byte steering of store mask/data by address offset, plus misalignment flag.
module memory_access_store_align
  import memory_access_pkg::*;
(
  input  logic                              load,
  input  logic [NUM_LANES-1:0]              size,
  input  logic [OFF_W-1:0]                  off,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  data,
  output logic [NUM_LANES-1:0]              we,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  wdata,
  output logic                              misaligned
);

  // Lane i takes source lane (i - off); lanes below the offset stay empty.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [OFF_W-1:0] LANE = OFF_W'(i);
    logic [OFF_W-1:0] src;
    logic             hit;
    assign src      = LANE - off;
    assign hit      = (off <= LANE);
    assign we[i]    = hit & size[src];
    assign wdata[i] = hit ? data[src] : '0;
  end

  assign misaligned = is_misaligned(load, size, off);

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: req/ack data bus access, stall while outstanding, writeback registers.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] alu_data_mem,
  input  logic                  reg_d_we_mem,
  input  logic [ADDR_WIDTH-1:0] reg_d_addr_mem,
  input  logic                  reg_d_data_sel_mem,
  input  logic [DATA_WIDTH-1:0] reg_t_data_mem,
  input  logic [3:0]            mem_we_mem,
  output logic [DATA_WIDTH-1:0] reg_d_data_mem,
  output logic                  stall_mem,
  output logic                  dmem_req,
  output logic [3:0]            dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  reg_d_we_wb,
  output logic [ADDR_WIDTH-1:0] reg_d_addr_wb,
  output logic [DATA_WIDTH-1:0] reg_d_data_wb,
  output logic                  misaligned_wb
);

  mem_state_e            state;
  logic                  load;
  logic                  misaligned;
  logic                  access;
  logic [OFF_W-1:0]      off;
  logic [NUM_LANES-1:0]  lane_we;
  logic [DATA_WIDTH-1:0] lane_wdata;

  assign off  = alu_data_mem[OFF_W-1:0];
  assign load = (reg_d_data_sel_mem == REG_D_DATA_SEL_MEM);

  memory_access_store_align u_align (
    .load       (load),
    .size       (mem_we_mem),
    .off        (off),
    .data       (reg_t_data_mem),
    .we         (lane_we),
    .wdata      (lane_wdata),
    .misaligned (misaligned)
  );

  assign access = (load | (mem_we_mem != MEM_SIZE_NONE)) & ~misaligned;

  // Upstream holds inputs during a stall, so bus fields are stable in WAIT.
  assign dmem_req       = rst_n & ((state == MEM_STATE_WAIT) | access);
  assign stall_mem      = dmem_req & ~dmem_ack;
  assign dmem_we        = dmem_req ? lane_we : '0;
  assign dmem_addr      = {alu_data_mem[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_wdata     = lane_wdata;
  assign reg_d_data_mem = alu_data_mem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= MEM_STATE_IDLE;
      reg_d_we_wb   <= 1'b0;
      reg_d_addr_wb <= '0;
      reg_d_data_wb <= '0;
      misaligned_wb <= 1'b0;
    end else begin
      case (state)
        MEM_STATE_IDLE: if (access && !dmem_ack) state <= MEM_STATE_WAIT;
        MEM_STATE_WAIT: if (dmem_ack)            state <= MEM_STATE_IDLE;
        default:                                 state <= MEM_STATE_IDLE;
      endcase

      if (stall_mem) begin
        reg_d_we_wb   <= 1'b0;
        misaligned_wb <= 1'b0;
      end else begin
        reg_d_we_wb   <= reg_d_we_mem & ~misaligned;
        reg_d_addr_wb <= reg_d_addr_mem;
        reg_d_data_wb <= (reg_d_data_sel_mem == REG_D_DATA_SEL_ALU) ? alu_data_mem : dmem_rdata;
        misaligned_wb <= misaligned;
      end
    end
  end

endmodule
